// File: rtl/natv_pkg.sv
// natv_pkg: shared types and widths for the native core bus responder.
//   natv_resp_state_e : responder FSM encoding (IDLE, WAIT, RESP)
//   natv_req_t        : one latched bus request (addr, wdata, wstrb)
//   NATV_DW/AW/SW     : data, address and strobe widths
package natv_pkg;

  localparam int NATV_DW = 32;
  localparam int NATV_AW = 32;
  localparam int NATV_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } natv_resp_state_e;

  typedef struct packed {
    logic [NATV_AW-1:0] addr;
    logic [NATV_DW-1:0] wdata;
    logic [NATV_SW-1:0] wstrb;
  } natv_req_t;

endpackage

// File: rtl/natv_ram_resp_mem.sv
// natv_ram_resp_mem: DEPTH x 32 word store with per-byte write enables and a
// combinational read port. Kept separate so it can be replaced by an SRAM macro.
//   clk   : clock
//   we    : byte write enables (one per byte lane), write on rising clk
//   idx   : word index, shared by read and write
//   wdata : write data
//   rdata : word at idx (combinational)
module natv_ram_resp_mem
  import natv_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic               clk,
  input  logic [NATV_SW-1:0] we,
  input  logic [IW-1:0]      idx,
  input  logic [NATV_DW-1:0] wdata,
  output logic [NATV_DW-1:0] rdata
);

  // Contents are deliberately not reset.
  logic [NATV_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NATV_SW; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/natv_ram_resp.sv
// natv_ram_resp: responder end of the native valid/ready core bus.
// Decodes a DEPTH*4-byte window at BASE_ADDR, serves single-word reads and
// byte-strobed writes from natv_ram_resp_mem, inserts wait_i wait states and
// flags out-of-window accesses.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   core_valid_i    : request valid (held by master until ready)
//   core_addr_i     : byte address (addr[1:0] ignored)
//   core_wdata_i    : write data
//   core_wstrb_i    : byte strobes, 4'b0000 means read
//   core_rdata_o    : read data, nonzero only in the ready cycle of a read
//   core_ready_o    : one-cycle acknowledge
//   wait_i          : wait states for the next accepted access (0..15)
//   err_o           : sticky out-of-window flag
//   err_clr_i       : clears err_o / err_cnt_o (wins over a simultaneous miss)
//   err_cnt_o       : saturating out-of-window access count
//
// Handshake: a transfer is requested while core_valid_i=1 and completes in the
// single cycle core_ready_o=1. The request is captured when IDLE samples
// core_valid_i; the master's inputs are not looked at again until the next
// IDLE, so a dropped valid or a changed wait_i cannot disturb an access in
// flight.
module natv_ram_resp
  import natv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_valid_i,
  input  logic [NATV_AW-1:0] core_addr_i,
  input  logic [NATV_DW-1:0] core_wdata_i,
  input  logic [NATV_SW-1:0] core_wstrb_i,
  output logic [NATV_DW-1:0] core_rdata_o,
  output logic               core_ready_o,
  input  logic [3:0]         wait_i,
  output logic               err_o,
  input  logic               err_clr_i,
  output logic [7:0]         err_cnt_o
);

  localparam int                 IW        = $clog2(DEPTH);
  localparam logic [NATV_AW-1:0] WIN_BYTES = NATV_AW'(DEPTH * 4);

  // FSM state is kept as a plain named signal so checkers can bind to it.
  natv_resp_state_e   state, state_n;
  natv_req_t          req_q;
  logic               hit_q;
  logic [3:0]         cnt_q;

  logic [NATV_AW-1:0] off, off_q;
  logic               hit;
  logic               accept, resp, is_read;
  logic [IW-1:0]      idx_q;
  logic [NATV_SW-1:0] mem_we;
  logic [NATV_DW-1:0] mem_rdata;
  logic               unused_off;

  // Unsigned subtraction: addresses below the base wrap to a huge offset and miss.
  assign off        = core_addr_i - BASE_ADDR;
  assign hit        = off < WIN_BYTES;
  assign off_q      = req_q.addr - BASE_ADDR;
  assign idx_q      = off_q[IW+1:2];
  assign unused_off = ^{off_q[NATV_AW-1:IW+2], off_q[1:0]};

  assign accept  = (state == IDLE) && core_valid_i;
  assign resp    = (state == RESP);
  assign is_read = (req_q.wstrb == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (core_valid_i) state_n = (wait_i == 4'd0) ? RESP : WAIT;
      // cnt was loaded with wait_i, so leaving at cnt==1 gives wait_i WAIT cycles.
      WAIT:    if (cnt_q == 4'd1) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= '0;
      hit_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (accept) begin
      req_q.addr  <= core_addr_i;
      req_q.wdata <= core_wdata_i;
      req_q.wstrb <= core_wstrb_i;
      hit_q       <= hit;
      cnt_q       <= wait_i;
    end else if (state == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Clear wins over a miss completing in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= 8'd0;
    end else if (err_clr_i) begin
      err_o     <= 1'b0;
      err_cnt_o <= 8'd0;
    end else if (resp && !hit_q) begin
      err_o <= 1'b1;
      if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  // Writes commit on the edge that ends RESP, before the next IDLE sample,
  // so a following read of the same word sees the new data.
  assign mem_we = (resp && hit_q) ? req_q.wstrb : '0;

  natv_ram_resp_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  assign core_ready_o = resp;
  assign core_rdata_o = (resp && is_read) ? (hit_q ? mem_rdata : ERR_RDATA) : '0;

endmodule

// File: tb/tb_natv_ram_resp.sv
// tb_natv_ram_resp: bench for natv_ram_resp. A driver task issues bus
// accesses and pushes the reference model's expected read data and latency;
// a negedge monitor pops and compares whenever core_ready_o is high.
module tb_natv_ram_resp;

  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int          DEPTH = 256;
  localparam logic [31:0] WIN   = 32'(DEPTH * 4);
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_valid_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [3:0]  core_wstrb_i;
  logic [31:0] core_rdata_o;
  logic        core_ready_o;
  logic [3:0]  wait_i;
  logic        err_o;
  logic        err_clr_i;
  logic [7:0]  err_cnt_o;

  natv_ram_resp #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .ERR_RDATA (ERRD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_valid_i (core_valid_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_wstrb_i (core_wstrb_i),
    .core_rdata_o (core_rdata_o),
    .core_ready_o (core_ready_o),
    .wait_i       (wait_i),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i),
    .err_cnt_o    (err_cnt_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model and scoreboard state ----------------
  logic [31:0] ref_mem [DEPTH];
  bit          err_m;
  int          cnt_m;
  logic [31:0] exp_q [$];
  int          lat_q [$];
  int          iss_q [$];
  int          vec  = 0;
  int          misc = 0;
  bit          prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] miss_addr();
    if ($urandom_range(0, 1) == 1) return BASE + WIN + 32'($urandom_range(0, 32'h00FF_FFFF));
    else                           return BASE - 32'd1 - 32'($urandom_range(0, 32'h3FFF));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [31:0] e;
    int          l, s;
    if (!rst_i) begin
      if (core_ready_o) begin
        check("ready_width", {31'd0, prev_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          vec++;
          misc++;
          $display("FAIL unexpected_ready: got ready=1 expected no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          s = iss_q.pop_front();
          check("rdata", core_rdata_o, e);
          // Issue happens just after edge s; ready is taken by the master at edge cyc+1.
          check("latency", 32'(cyc - s + 1), 32'(l));
        end
      end else if (exp_q.size() != 0) begin
        check("rdata_not_ready", core_rdata_o, 32'd0);
      end
    end
    prev_ready = core_ready_o;
  end

  // ---------------- driver ----------------
  // Entered and left just after a rising edge, so consecutive calls run back to back.
  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [3:0] w,
                            input bit chg_wait, input bit clr_in_resp);
    logic [31:0] off;
    int          idx;
    bit          hit, got;
    logic [31:0] exp_rd;
    off    = addr - BASE;
    hit    = (off < WIN);
    idx    = int'(off / 4);
    exp_rd = 32'd0;
    if (hit) begin
      if (wstrb == 4'd0) exp_rd = ref_mem[idx];
      else for (int b = 0; b < 4; b++) if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      if (wstrb == 4'd0) exp_rd = ERRD;
      err_m = 1'b1;
      if (cnt_m < 255) cnt_m++;
    end
    if (clr_in_resp) begin
      err_m = 1'b0;
      cnt_m = 0;
    end
    exp_q.push_back(exp_rd);
    lat_q.push_back(int'(w) + 2);
    iss_q.push_back(cyc);

    core_valid_i = 1'b1;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    core_wstrb_i = wstrb;
    wait_i       = w;
    got          = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (chg_wait && i == 2) wait_i = 4'd0;
      if (core_ready_o) begin
        got = 1'b1;
        if (clr_in_resp) err_clr_i = 1'b1;
      end
    end
    if (!got) begin
      vec++;
      misc++;
      $display("FAIL ready_timeout: got no ready expected ready within 40 cycles (addr %h)", addr);
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      void'(iss_q.pop_back());
    end
    @(posedge clk);
    #1;
    core_valid_i = 1'b0;
    err_clr_i    = 1'b0;
    core_addr_i  = $urandom;
    core_wdata_i = $urandom;
    core_wstrb_i = 4'($urandom_range(0, 15));
    check("err_o", {31'd0, err_o}, {31'd0, err_m});
    check("err_cnt", {24'd0, err_cnt_o}, 32'(cnt_m));
  endtask

  task automatic err_clear();
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    err_m = 1'b0;
    cnt_m = 0;
    check("err_o_clr", {31'd0, err_o}, 32'd0);
    check("err_cnt_clr", {24'd0, err_cnt_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] a;
    logic [3:0]  s;
    rst_i        = 1'b1;
    core_valid_i = 1'b0;
    core_addr_i  = 32'd0;
    core_wdata_i = 32'd0;
    core_wstrb_i = 4'd0;
    wait_i       = 4'd0;
    err_clr_i    = 1'b0;
    err_m        = 1'b0;
    cnt_m        = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

    #12;
    check("rst_ready", {31'd0, core_ready_o}, 32'd0);
    check("rst_rdata", core_rdata_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Array is not reset: give every word a known value first.
    for (int i = 0; i < DEPTH; i++) bus_access(BASE + 32'(4 * i), 32'd0, 4'hF, 4'd0, 1'b0, 1'b0);

    // Write then read, no wait states.
    bus_access(BASE + 32'h10, 32'h1234_5678, 4'hF, 4'd0, 1'b0, 1'b0);
    bus_access(BASE + 32'h10, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Byte strobes.
    bus_access(BASE + 32'h4, 32'hAABB_CCDD, 4'hF, 4'd0, 1'b0, 1'b0);
    bus_access(BASE + 32'h4, 32'h1122_3344, 4'b0101, 4'd0, 1'b0, 1'b0);
    bus_access(BASE + 32'h4, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Wait states, then wait_i changed mid-access.
    bus_access(BASE + 32'h0, 32'd0, 4'h0, 4'd5, 1'b0, 1'b0);
    bus_access(BASE + 32'h0, 32'd0, 4'h0, 4'd5, 1'b1, 1'b0);
    bus_access(BASE + 32'h10, 32'd0, 4'h0, 4'd15, 1'b0, 1'b0);

    // Out of window: first word past the top, then just below the base.
    bus_access(BASE + WIN, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    bus_access(BASE - 32'd4, 32'h5555_AAAA, 4'hF, 4'd1, 1'b0, 1'b0);
    // Dropped miss write must not alias onto any in-window word.
    bus_access(BASE + 32'(4 * (DEPTH - 1)), 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    bus_access(BASE + 32'h0, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);
    // Third miss with a clear in its RESP cycle.
    bus_access(miss_addr(), 32'd0, 4'h0, 4'd2, 1'b0, 1'b1);

    // Saturation.
    for (int i = 0; i < 300; i++)
      bus_access(miss_addr(), $urandom, 4'($urandom_range(0, 15)), 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a waited write.
    core_valid_i = 1'b1;
    core_addr_i  = BASE + 32'h8;
    core_wdata_i = 32'hFFFF_FFFF;
    core_wstrb_i = 4'hF;
    wait_i       = 4'd8;
    repeat (4) @(negedge clk);
    check("ready_in_wait", {31'd0, core_ready_o}, 32'd0);
    #1;
    rst_i = 1'b1;
    #1;
    check("ready_on_rst", {31'd0, core_ready_o}, 32'd0);
    check("rdata_on_rst", core_rdata_o, 32'd0);
    check("err_cnt_on_rst", {24'd0, err_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    core_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    err_m = 1'b0;
    cnt_m = 0;
    bus_access(BASE + 32'h8, 32'd0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Randomized mix of hits, misses, reads, partial writes and waits.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) a = miss_addr();
      else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      bus_access(a, $urandom, s, 4'($urandom_range(0, 3)), 1'b0, 1'b0);
      if ($urandom_range(0, 29) == 0) err_clear();
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
